// File: rtl/instruction_fetcher.sv
// instruction_fetcher: per-core fetch engine. It issues one program-memory read
// per instruction over a valid/ready channel and holds the returned word for
// the decoder.
// Optional feature macro: FETCH_CACHE_EN adds a one-entry tag register. When the
// requested PC matches the tag, the fetch completes without a memory request.
module instruction_fetcher #(
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
  parameter int unsigned PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

  localparam int unsigned AW = PROGRAM_MEM_ADDR_BITS;
  localparam int unsigned DW = PROGRAM_MEM_DATA_BITS;

  // Scheduler states this block reacts to
  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  // Fetcher state encoding, visible to the scheduler
  localparam logic [2:0] S_IDLE     = 3'b000;
  localparam logic [2:0] S_FETCHING = 3'b001;
  localparam logic [2:0] S_FETCHED  = 3'b010;

  logic [2:0]    state_nxt;
  logic          valid_nxt;
  logic [AW-1:0] addr_nxt;
  logic [DW-1:0] instr_nxt;
  logic          cache_hit_c;

`ifdef FETCH_CACHE_EN
  logic          tag_valid;
  logic [AW-1:0] tag_addr;

  assign cache_hit_c = tag_valid && (current_pc == tag_addr);

  // Remember the address of every captured word; only reset clears the tag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tag_valid <= 1'b0;
      tag_addr  <= AW'(0);
    end else if (fetcher_state == S_FETCHING && mem_read_ready) begin
      tag_valid <= 1'b1;
      tag_addr  <= mem_read_address;
    end
  end
`else
  assign cache_hit_c = 1'b0;
`endif

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetcher_state    <= S_IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= AW'(0);
      instruction      <= DW'(0);
    end else begin
      fetcher_state    <= state_nxt;
      mem_read_valid   <= valid_nxt;
      mem_read_address <= addr_nxt;
      instruction      <= instr_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = fetcher_state;
    case (fetcher_state)
      S_IDLE: begin
        if (core_state == CORE_FETCH) begin
          state_nxt = cache_hit_c ? S_FETCHED : S_FETCHING;
        end
      end
      S_FETCHING: begin
        if (mem_read_ready) begin
          state_nxt = S_FETCHED;
        end
      end
      S_FETCHED: begin
        if (core_state == CORE_DECODE) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    valid_nxt = mem_read_valid;
    addr_nxt  = mem_read_address;
    instr_nxt = instruction;
    case (fetcher_state)
      S_IDLE: begin
        if (core_state == CORE_FETCH && !cache_hit_c) begin
          valid_nxt = 1'b1;
          addr_nxt  = current_pc;
        end
      end
      S_FETCHING: begin
        if (mem_read_ready) begin
          valid_nxt = 1'b0;
          instr_nxt = mem_read_data;
        end
      end
      S_FETCHED: begin
        valid_nxt = 1'b0;
      end
      default: valid_nxt = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Testbench for instruction_fetcher: directed scenarios followed by randomized
// traffic, compared every cycle against a rule-level reference model.
module tb_instruction_fetcher;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  localparam logic [2:0] C_IDLE    = 3'b000;
  localparam logic [2:0] C_FETCH   = 3'b001;
  localparam logic [2:0] C_DECODE  = 3'b010;
  localparam logic [2:0] C_REQUEST = 3'b011;

`ifdef FETCH_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    core_state;
  logic [AW-1:0] current_pc;
  logic          mem_read_valid;
  logic [AW-1:0] mem_read_address;
  logic          mem_read_ready;
  logic [DW-1:0] mem_read_data;
  logic [2:0]    fetcher_state;
  logic [DW-1:0] instruction;

  instruction_fetcher #(
    .PROGRAM_MEM_ADDR_BITS(AW),
    .PROGRAM_MEM_DATA_BITS(DW)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 = idle, 1 = waiting on memory, 2 = word available
  int            m_st    = 0;
  logic          m_valid = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_instr = '0;
  logic          m_tag_v = 1'b0;
  logic [AW-1:0] m_tag_a = '0;

  logic [DW-1:0] mem [256];
  bit            rand_phase = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the behavioural rules for one clock edge using the inputs now driven
  task automatic model_edge();
    if (!reset_n) begin
      m_st = 0; m_valid = 1'b0; m_addr = '0; m_instr = '0; m_tag_v = 1'b0;
      return;
    end
    case (m_st)
      0: if (core_state == C_FETCH) begin
           if (CACHE && m_tag_v && current_pc == m_tag_a) begin
             m_st = 2;
           end else begin
             m_st = 1; m_valid = 1'b1; m_addr = current_pc;
           end
         end
      1: if (mem_read_ready) begin
           m_st = 2; m_valid = 1'b0; m_instr = mem_read_data;
           m_tag_v = 1'b1; m_tag_a = m_addr;
         end
      default: if (core_state == C_DECODE) m_st = 0;
    endcase
  endtask

  // Advance one clock, then compare every output against the model
  task automatic tick();
    bit cap;
    cap = reset_n && (m_st == 1) && mem_read_ready;
    model_edge();
    @(posedge clk);
    #1;
    chk("state", 32'(fetcher_state), 32'(m_st));
    chk("valid", 32'(mem_read_valid), 32'(m_valid));
    chk("addr", 32'(mem_read_address), 32'(m_addr));
    chk("instr", 32'(instruction), 32'(m_instr));
    if (rand_phase && cap) chk("rand_capture", 32'(instruction), 32'(mem[m_addr]));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);

    // Test 1: reset for two cycles with ready held high
    reset_n = 1'b0; core_state = C_IDLE; current_pc = '0;
    mem_read_ready = 1'b1; mem_read_data = 16'h5555;
    tick(); tick();
    chk("t1_state", 32'(fetcher_state), 32'h0);
    chk("t1_valid", 32'(mem_read_valid), 32'h0);
    chk("t1_instr", 32'(instruction), 32'h0);
    reset_n = 1'b1; mem_read_ready = 1'b0;

    // Test 2: ready returned in the third cycle of valid
    core_state = C_FETCH; current_pc = 8'h05;
    tick();
    chk("t2_valid1", 32'(mem_read_valid), 32'h1);
    chk("t2_addr1", 32'(mem_read_address), 32'h05);
    tick();
    chk("t2_valid2", 32'(mem_read_valid), 32'h1);
    tick();
    chk("t2_valid3", 32'(mem_read_valid), 32'h1);
    chk("t2_addr3", 32'(mem_read_address), 32'h05);
    mem_read_ready = 1'b1; mem_read_data = 16'h3A7F;
    tick();
    chk("t2_state", 32'(fetcher_state), 32'h2);
    chk("t2_instr", 32'(instruction), 32'h3A7F);
    chk("t2_valid_off", 32'(mem_read_valid), 32'h0);
    mem_read_ready = 1'b0;

    // Test 4: non-DECODE holds FETCHED, DECODE releases to IDLE
    core_state = C_REQUEST;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_hold", 32'(fetcher_state), 32'h2);
    core_state = C_DECODE;
    tick();
    chk("t4_idle", 32'(fetcher_state), 32'h0);
    chk("t4_instr", 32'(instruction), 32'h3A7F);
    core_state = C_IDLE;

    // Test 3: ready tied high gives the minimum two-edge latency
    mem_read_ready = 1'b1; mem_read_data = 16'h1234;
    core_state = C_FETCH; current_pc = 8'h00;
    tick();
    chk("t3_edge1", 32'(fetcher_state), 32'h1);
    tick();
    chk("t3_edge2", 32'(fetcher_state), 32'h2);
    chk("t3_instr", 32'(instruction), 32'h1234);
    core_state = C_DECODE;
    tick();
    core_state = C_IDLE;
    tick();
    chk("t3_idle_ignores_ready", 32'(instruction), 32'h1234);
    mem_read_ready = 1'b0;

    // Test 5: reset mid-fetch, then a late ready must be ignored
    core_state = C_FETCH; current_pc = 8'h22;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; core_state = C_IDLE;
    mem_read_ready = 1'b1; mem_read_data = 16'hFFFF;
    tick();
    chk("t5_state", 32'(fetcher_state), 32'h0);
    chk("t5_valid", 32'(mem_read_valid), 32'h0);
    chk("t5_instr", 32'(instruction), 32'h0);
    mem_read_ready = 1'b0;

    // PC change and core_state leaving FETCH while the request is pending
    core_state = C_FETCH; current_pc = 8'h30;
    tick();
    core_state = C_DECODE; current_pc = 8'h31;
    tick();
    chk("pc_latched", 32'(mem_read_address), 32'h30);
    chk("req_kept", 32'(mem_read_valid), 32'h1);
    mem_read_ready = 1'b1; mem_read_data = 16'hAAAA;
    tick();
    chk("late_capture", 32'(instruction), 32'hAAAA);
    mem_read_ready = 1'b0;
    tick();
    chk("late_release", 32'(fetcher_state), 32'h0);

    // Test 6: refetch of the same PC
    core_state = C_FETCH; current_pc = 8'h10;
    mem_read_ready = 1'b1; mem_read_data = 16'hBEEF;
    tick(); tick();
    chk("t6_first", 32'(instruction), 32'hBEEF);
    core_state = C_DECODE; mem_read_ready = 1'b0; mem_read_data = 16'h0000;
    tick();
    core_state = C_FETCH;
    tick();
`ifdef FETCH_CACHE_EN
    chk("t6_hit_state", 32'(fetcher_state), 32'h2);
    chk("t6_hit_valid", 32'(mem_read_valid), 32'h0);
    chk("t6_hit_instr", 32'(instruction), 32'hBEEF);
`else
    chk("t6_miss_state", 32'(fetcher_state), 32'h1);
    chk("t6_miss_valid", 32'(mem_read_valid), 32'h1);
    chk("t6_miss_addr", 32'(mem_read_address), 32'h10);
    mem_read_ready = 1'b1; mem_read_data = 16'hBEEF;
    tick();
    mem_read_ready = 1'b0;
`endif
    core_state = C_DECODE;
    tick();

    // Randomized traffic from a read-only program memory
    rand_phase = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      if (m_st == 2)
        core_state = ($urandom_range(0, 1) == 0) ? C_DECODE : 3'($urandom_range(3, 7));
      else
        core_state = ($urandom_range(0, 2) != 0) ? C_FETCH : 3'($urandom);
      current_pc = AW'($urandom_range(0, 7));
      if (mem_read_valid) begin
        mem_read_ready = ($urandom_range(0, 2) == 0);
        mem_read_data  = mem_read_ready ? mem[mem_read_address] : DW'($urandom);
      end else begin
        mem_read_ready = ($urandom_range(0, 7) == 0);
        mem_read_data  = DW'($urandom);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
